controle_termostato: RTL

Thermostat command generator: the initiator side of the aumenta/diminui step interface that the air-conditioner plant FSM consumes.
- Latches a user target temperature from the switches.
- Compares it with the temperature the plant reports.
- Issues one-degree step requests (aumenta / diminui), each held until the plant acknowledges it.
- Flags a stuck plant (timeout) and a dripping condition.
- Sits in top between SWI decoding and the plant FSM; outputs go to LED/SEG.

---
 rtl/controle_termostato_pkg.sv | 27 ++
 rtl/controle_termostato_if.sv | 26 ++
 rtl/controle_termostato_contador_sat.sv | 35 +++
 rtl/controle_termostato.sv | 109 ++++++++++
 4 files changed

// File: rtl/controle_termostato_pkg.sv
// Shared thermostat definitions: temperature range, state encoding and the
// target clamp. The plant FSM imports the same package, so both sides agree
// on the step-interface state values.
package termostato_pkg;

    localparam int TW = 5;

    localparam logic [TW-1:0] TEMP_MIN = TW'(20);
    localparam logic [TW-1:0] TEMP_MAX = TW'(27);

    typedef enum logic [1:0] {
        OCIOSO          = 2'd0,
        PEDE_AUMENTO    = 2'd1,
        PEDE_DIMINUICAO = 2'd2,
        FALHA           = 2'd3
    } estado_t;

    // Force a requested temperature into the legal [TEMP_MIN, TEMP_MAX] range.
    function automatic logic [TW-1:0] clamp_temp(input logic [TW-1:0] t);
        logic [TW-1:0] r;
        r = t;
        if (t < TEMP_MIN) r = TEMP_MIN;
        else if (t > TEMP_MAX) r = TEMP_MAX;
        return r;
    endfunction

endpackage

// File: rtl/controle_termostato_if.sv
// Step interface between the thermostat (master) and the air-conditioner
// plant (slave): +1/-1 degree requests held until a one-cycle ack, plus the
// temperature the plant currently reports.
interface controle_termostato_if;
    import termostato_pkg::*;

    logic          aumenta;
    logic          diminui;
    logic          ack;
    logic [TW-1:0] real_in;

    modport master (
        output aumenta,
        output diminui,
        input  ack,
        input  real_in
    );

    modport slave (
        input  aumenta,
        input  diminui,
        output ack,
        output real_in
    );

endinterface

// File: rtl/controle_termostato_contador_sat.sv
// Saturating up-counter with synchronous clear. Clear wins over increment;
// once the count reaches MAX it holds there until cleared.
module contador_sat #(
    parameter int MAX = 15,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/controle_termostato.sv
// Thermostat command generator. Latches a clamped target, compares it with
// the plant temperature and issues one-degree step requests over the step
// interface, each held until acked. A request that waits TIMEOUT cycles
// without ack parks the controller in FALHA until a new target is loaded.
// A drip flag rises after PING_CYCLES idle cycles sitting at TEMP_MIN.
module controle_termostato
    import termostato_pkg::*;
#(
    parameter int TIMEOUT     = 15,
    parameter int PING_CYCLES = 8
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic [TW-1:0]         desejo_in,
    input  logic                  carregar,
    controle_termostato_if.master passo,
    output logic [TW-1:0]         alvo,
    output logic                  falha,
    output logic                  pingando,
    output logic [1:0]            estado
);

    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int PING_W = $clog2(PING_CYCLES + 1);

    estado_t       estado_q, estado_d;
    logic [TW-1:0] alvo_q, alvo_d;
    logic          aumenta_q, diminui_q, falha_q;

    logic [TMO_W-1:0]  tmo_cnt;
    logic [PING_W-1:0] ping_cnt;
    logic              pedindo;
    logic              tmo_hit;
    logic              drip_ok;

    assign pedindo = (estado_q == PEDE_AUMENTO) || (estado_q == PEDE_DIMINUICAO);
    // The cycle being judged is the TIMEOUT-th one spent waiting.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign drip_ok = (estado_q == OCIOSO) && (passo.real_in == alvo_q) &&
                     (alvo_q == TEMP_MIN);

    // Cycles the current request has waited; restarts for every new request.
    contador_sat #(.MAX(TIMEOUT), .W(TMO_W)) u_timeout (
        .clk_i   (clk_2),
        .rst_n_i (reset_n),
        .clr_i   (!pedindo || passo.ack),
        .inc_i   (pedindo),
        .cnt_o   (tmo_cnt)
    );

    // Consecutive idle cycles at the minimum temperature.
    contador_sat #(.MAX(PING_CYCLES), .W(PING_W)) u_pinga (
        .clk_i   (clk_2),
        .rst_n_i (reset_n),
        .clr_i   (!drip_ok),
        .inc_i   (drip_ok),
        .cnt_o   (ping_cnt)
    );

    // Target latch; a new target is accepted in every state.
    always_comb begin
        alvo_d = alvo_q;
        if (carregar) alvo_d = clamp_temp(desejo_in);
    end

    // Next-state decision; ack has priority over the timeout.
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            OCIOSO: begin
                if (passo.real_in < alvo_q)      estado_d = PEDE_AUMENTO;
                else if (passo.real_in > alvo_q) estado_d = PEDE_DIMINUICAO;
            end
            PEDE_AUMENTO, PEDE_DIMINUICAO: begin
                if (passo.ack)    estado_d = OCIOSO;
                else if (tmo_hit) estado_d = FALHA;
            end
            FALHA: begin
                if (carregar) estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // State, target and registered Moore outputs.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            estado_q  <= OCIOSO;
            alvo_q    <= TEMP_MIN;
            aumenta_q <= 1'b0;
            diminui_q <= 1'b0;
            falha_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            alvo_q    <= alvo_d;
            aumenta_q <= (estado_d == PEDE_AUMENTO);
            diminui_q <= (estado_d == PEDE_DIMINUICAO);
            falha_q   <= (estado_d == FALHA);
        end
    end

    assign passo.aumenta = aumenta_q;
    assign passo.diminui = diminui_q;
    assign alvo          = alvo_q;
    assign falha         = falha_q;
    assign pingando      = (ping_cnt == PING_W'(PING_CYCLES));
    assign estado        = estado_q;

endmodule
